bubbledrive8_supervisor: RTL and testbench

Parametrised power-mode supervisor for the BubbleDrive8 top level. It decides between the emulator, MPSSE standby and error modes from the PWRSTAT and MRST board-status inputs, and drives the active-low enables of the emucore, tempsense and usb cores. It also drives the three status LEDs. Over the current startup controller it adds:
- per-input synchronisation and debounce;
- a bounded drain interval before any mode change;
- exit from emulator mode when board power drops;
- a slow/fast blink generator with phase restart.

---
 rtl/bubbledrive8_pkg.sv | 54 +++++
 rtl/bubbledrive8_debounce.sv | 67 ++++++
 rtl/bubbledrive8_supervisor.sv | 158 +++++++++++++++
 tb/tb_bubbledrive8_supervisor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bubbledrive8_pkg.sv
// Shared state codes, LED mode encoding and small decode helpers for the
// BubbleDrive8 power-mode supervisor.
package bubbledrive8_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET    = 3'b000,
    ST_SETTLE   = 3'b001,
    ST_EMULATOR = 3'b010,
    ST_DRAIN    = 3'b011,
    ST_MPSSE    = 3'b101,
    ST_ERR_MRST = 3'b110,
    ST_ERR_USB  = 3'b111
  } state_e;

  typedef enum logic [1:0] {
    LED_OFF  = 2'd0,
    LED_ON   = 2'd1,
    LED_SLOW = 2'd2,
    LED_FAST = 2'd3
  } led_mode_e;

  // Active-low core enables, one bit per core.
  typedef struct packed {
    logic emucore;
    logic tempsense;
    logic usb;
  } enables_t;

  // Active-low LED pin level for a mode, given the current blink phases.
  function automatic logic led_level(led_mode_e mode, logic slow_lit, logic fast_lit);
    logic lvl;
    case (mode)
      LED_ON:   lvl = 1'b0;
      LED_SLOW: lvl = ~slow_lit;
      LED_FAST: lvl = ~fast_lit;
      default:  lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  // Core enables driven while sitting in a given state.
  function automatic enables_t state_enables(state_e s);
    enables_t en;
    case (s)
      ST_EMULATOR: en = '{emucore: 1'b0, tempsense: 1'b0, usb: 1'b0};
      ST_MPSSE:    en = '{emucore: 1'b1, tempsense: 1'b1, usb: 1'b0};
      default:     en = '{emucore: 1'b1, tempsense: 1'b1, usb: 1'b1};
    endcase
    return en;
  endfunction

endpackage

// File: rtl/bubbledrive8_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer. The debounced
// level and its valid flag appear 2 + DEBOUNCE_CYCLES cycles after an input
// change (or after reset release).
module bubbledrive8_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4800,
  parameter int unsigned CNT_W           = 24
) (
  input  logic MCLK,
  input  logic nRST,
  input  logic i_async,
  output logic o_level,
  output logic o_valid
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_fill1;
  logic             r_fill2;
  logic             r_cand_ok;
  logic             r_cand;
  logic             r_level;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  // Synchroniser; r_fill marks when r_sync2 holds a real sample after reset.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_fill1 <= 1'b0;
      r_fill2 <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_fill1 <= 1'b1;
      r_fill2 <= r_fill1;
    end
  end

  // Candidate tracking: restart the count on any difference, commit when stable.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_cand_ok <= 1'b0;
      r_cand    <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_valid   <= 1'b0;
    end else if (r_fill2) begin
      if (!r_cand_ok || (r_sync2 != r_cand)) begin
        r_cand_ok <= 1'b1;
        r_cand    <= r_sync2;
        r_cnt     <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_cand;
        r_valid <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_valid = r_valid;

endmodule

// File: rtl/bubbledrive8_supervisor.sv
// Power-mode supervisor: chooses emulator / MPSSE standby / error modes from
// debounced PWRSTAT and MRST, drives the active-low core enables with a drain
// gap between enabled modes, and drives the three status LEDs.
module bubbledrive8_supervisor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4800,
  parameter int unsigned BLINK_HALF      = 8192,
  parameter int unsigned DRAIN_CYCLES    = 48,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       MCLK,
  input  logic       nRST,
  input  logic       PWRSTAT,
  input  logic       MRST,
  input  logic       nDELAYING,
  output logic       nEMUCORE_EN,
  output logic       nTEMPSENSE_EN,
  output logic       nUSB_EN,
  output logic       nLED_PWROK,
  output logic       nLED_STANDBY,
  output logic       nLED_DELAYING,
  output logic [2:0] STATE
);

  import bubbledrive8_pkg::*;

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] BLINK_MID  = CNT_W'((BLINK_HALF / 2) - 1);

  logic             w_pwr_level;
  logic             w_pwr_valid;
  logic             w_mrst_level;
  logic             w_mrst_valid;
  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_slow_lit;
  logic             r_fast_lit;
  led_mode_e        w_mode_pwrok;
  led_mode_e        w_mode_standby;
  enables_t         r_en;
  logic             r_led_pwrok;
  logic             r_led_standby;
  logic             r_led_delaying;

  bubbledrive8_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_pwrstat (
    .MCLK   (MCLK),
    .nRST   (nRST),
    .i_async(PWRSTAT),
    .o_level(w_pwr_level),
    .o_valid(w_pwr_valid)
  );

  bubbledrive8_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_mrst (
    .MCLK   (MCLK),
    .nRST   (nRST),
    .i_async(MRST),
    .o_level(w_mrst_level),
    .o_valid(w_mrst_valid)
  );

  // Next-state decode; DRAIN ignores the inputs until its count expires.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RESET: w_next_state = ST_SETTLE;
      ST_SETTLE: begin
        if (w_pwr_valid && w_mrst_valid) begin
          case ({w_pwr_level, w_mrst_level})
            2'b00:   w_next_state = ST_EMULATOR;
            2'b01:   w_next_state = ST_ERR_MRST;
            2'b10:   w_next_state = ST_ERR_USB;
            default: w_next_state = ST_MPSSE;
          endcase
        end
      end
      ST_EMULATOR: if (w_mrst_level) w_next_state = ST_DRAIN;
      ST_MPSSE:    if (!w_pwr_level && !w_mrst_level) w_next_state = ST_DRAIN;
      ST_ERR_MRST: if (!w_mrst_level) w_next_state = ST_SETTLE;
      ST_ERR_USB:  if ({w_pwr_level, w_mrst_level} != 2'b10) w_next_state = ST_SETTLE;
      ST_DRAIN:    if (r_drain_cnt == DRAIN_LAST) w_next_state = ST_SETTLE;
      default:     w_next_state = ST_RESET;
    endcase
  end

  // State register plus drain and blink timers; any transition restarts both.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_RESET;
      r_drain_cnt <= '0;
      r_blink_cnt <= '0;
      r_slow_lit  <= 1'b1;
      r_fast_lit  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        r_drain_cnt <= '0;
        r_blink_cnt <= '0;
        r_slow_lit  <= 1'b1;
        r_fast_lit  <= 1'b1;
      end else begin
        r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + CNT_W'(1) : '0;
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_slow_lit  <= ~r_slow_lit;
          r_fast_lit  <= ~r_fast_lit;
        end else begin
          r_blink_cnt <= r_blink_cnt + CNT_W'(1);
          if (r_blink_cnt == BLINK_MID) r_fast_lit <= ~r_fast_lit;
        end
      end
    end
  end

  // LED mode per state.
  always_comb begin
    w_mode_pwrok   = LED_OFF;
    w_mode_standby = LED_OFF;
    case (r_state)
      ST_EMULATOR: w_mode_pwrok   = LED_ON;
      ST_MPSSE:    w_mode_standby = LED_SLOW;
      ST_ERR_MRST: w_mode_pwrok   = LED_SLOW;
      ST_ERR_USB:  w_mode_pwrok   = LED_FAST;
      default:     ;
    endcase
  end

  // Registered enables and LEDs, one cycle behind the state register.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_en           <= '1;
      r_led_pwrok    <= 1'b1;
      r_led_standby  <= 1'b1;
      r_led_delaying <= 1'b1;
    end else begin
      r_en           <= state_enables(r_state);
      r_led_pwrok    <= led_level(w_mode_pwrok, r_slow_lit, r_fast_lit);
      r_led_standby  <= nDELAYING ? led_level(w_mode_standby, r_slow_lit, r_fast_lit) : 1'b0;
      r_led_delaying <= (r_state == ST_EMULATOR) ? nDELAYING : 1'b1;
    end
  end

  assign nEMUCORE_EN   = r_en.emucore;
  assign nTEMPSENSE_EN = r_en.tempsense;
  assign nUSB_EN       = r_en.usb;
  assign nLED_PWROK    = r_led_pwrok;
  assign nLED_STANDBY  = r_led_standby;
  assign nLED_DELAYING = r_led_delaying;
  assign STATE         = r_state;

endmodule

// File: tb/tb_bubbledrive8_supervisor.sv
// Scoreboard bench for bubbledrive8_supervisor: the stimulus process schedules
// expected output vectors against absolute cycle numbers; the monitor samples
// the outputs 1 time unit after each rising edge and compares due entries.
module tb_bubbledrive8_supervisor;

  logic       MCLK;
  logic       nRST;
  logic       PWRSTAT;
  logic       MRST;
  logic       nDELAYING;
  logic       nEMUCORE_EN;
  logic       nTEMPSENSE_EN;
  logic       nUSB_EN;
  logic       nLED_PWROK;
  logic       nLED_STANDBY;
  logic       nLED_DELAYING;
  logic [2:0] STATE;

  bubbledrive8_supervisor #(
    .DEBOUNCE_CYCLES(16),
    .BLINK_HALF     (8),
    .DRAIN_CYCLES   (4),
    .CNT_W          (24)
  ) dut (
    .MCLK         (MCLK),
    .nRST         (nRST),
    .PWRSTAT      (PWRSTAT),
    .MRST         (MRST),
    .nDELAYING    (nDELAYING),
    .nEMUCORE_EN  (nEMUCORE_EN),
    .nTEMPSENSE_EN(nTEMPSENSE_EN),
    .nUSB_EN      (nUSB_EN),
    .nLED_PWROK   (nLED_PWROK),
    .nLED_STANDBY (nLED_STANDBY),
    .nLED_DELAYING(nLED_DELAYING),
    .STATE        (STATE)
  );

  // Vector layout: {STATE[2:0], nEMU, nTEMP, nUSB, nPWROK, nSTANDBY, nDELAYING}
  localparam logic [8:0] M_ALL   = 9'b111_111_111;
  localparam logic [8:0] M_ST_EN = 9'b111_111_000;
  localparam logic [8:0] M_ST    = 9'b111_000_000;

  typedef struct {
    int unsigned cyc;
    logic [8:0]  mask;
    logic [8:0]  val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int unsigned b;

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  function automatic logic [8:0] vec(input logic [2:0] st, input logic [2:0] en, input logic [2:0] led);
    return {st, en, led};
  endfunction

  function automatic logic [8:0] outs();
    return {STATE, nEMUCORE_EN, nTEMPSENSE_EN, nUSB_EN, nLED_PWROK, nLED_STANDBY, nLED_DELAYING};
  endfunction

  // Insert an expectation keeping the queue ordered by cycle.
  task automatic expect_at(input int unsigned c, input logic [8:0] m, input logic [8:0] v, input string nm);
    exp_t it;
    int   idx;
    it.cyc  = c;
    it.mask = m;
    it.val  = v;
    it.name = nm;
    idx = 0;
    while (idx < sb.size() && sb[idx].cyc <= c) idx++;
    sb.insert(idx, it);
  endtask

  task automatic compare(input exp_t it, input logic [8:0] act);
    checks++;
    if (it.cyc != cyc || ((act & it.mask) !== (it.val & it.mask))) begin
      failures++;
      $display("FAIL %s cyc=%0d due=%0d got=%b want=%b mask=%b", it.name, cyc, it.cyc, act, it.val, it.mask);
    end
  endtask

  // Immediate check, used where the response must not wait for a clock edge.
  task automatic check_now(input string nm, input logic [8:0] want);
    logic [8:0] act;
    act = outs();
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, act, want);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge MCLK);
    #2;
  endtask

  // Monitor: sample after each edge and retire every due expectation.
  initial begin
    exp_t it;
    forever begin
      @(posedge MCLK);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        it = sb.pop_front();
        compare(it, outs());
      end
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0; PWRSTAT = 1'b0; MRST = 1'b0; nDELAYING = 1'b1;
    wait_cycles(3);
    check_now("reset_values", vec(3'b000, 3'b111, 3'b111));

    // Power-up into EMULATOR.
    nRST = 1'b1; b = cyc;
    expect_at(b + 1,  M_ALL, vec(3'b001, 3'b111, 3'b111), "settle_first");
    expect_at(b + 18, M_ALL, vec(3'b001, 3'b111, 3'b111), "settle_last");
    expect_at(b + 19, M_ALL, vec(3'b010, 3'b111, 3'b111), "emu_entry");
    expect_at(b + 20, M_ALL, vec(3'b010, 3'b000, 3'b011), "emu_outputs");
    wait_cycles(25);

    // 10-cycle MRST glitch is filtered.
    b = cyc; MRST = 1'b1;
    for (int i = 0; i < 4; i++)
      expect_at(b + 5 + 8 * i, M_ALL, vec(3'b010, 3'b000, 3'b011), "glitch_hold");
    wait_cycles(10); MRST = 1'b0;
    wait_cycles(25);

    // Board power loss: EMULATOR -> DRAIN -> SETTLE -> ERR_MRST, slow blink.
    b = cyc; MRST = 1'b1;
    expect_at(b + 18, M_ALL, vec(3'b010, 3'b000, 3'b011), "pre_drain");
    expect_at(b + 19, M_ALL, vec(3'b011, 3'b000, 3'b011), "drain_entry");
    expect_at(b + 20, M_ALL, vec(3'b011, 3'b111, 3'b111), "drain_en_off");
    expect_at(b + 22, M_ALL, vec(3'b011, 3'b111, 3'b111), "drain_last");
    expect_at(b + 23, M_ALL, vec(3'b001, 3'b111, 3'b111), "drain_to_settle");
    expect_at(b + 24, M_ALL, vec(3'b110, 3'b111, 3'b111), "errmrst_entry");
    expect_at(b + 25, M_ALL, vec(3'b110, 3'b111, 3'b011), "errmrst_lit_first");
    expect_at(b + 32, M_ALL, vec(3'b110, 3'b111, 3'b011), "errmrst_lit_last");
    expect_at(b + 33, M_ALL, vec(3'b110, 3'b111, 3'b111), "errmrst_dark_first");
    expect_at(b + 40, M_ALL, vec(3'b110, 3'b111, 3'b111), "errmrst_dark_last");
    expect_at(b + 41, M_ALL, vec(3'b110, 3'b111, 3'b011), "errmrst_relit");
    wait_cycles(45);

    // USB power, board good: ERR_MRST -> SETTLE -> ERR_USB, fast blink.
    b = cyc; PWRSTAT = 1'b1; MRST = 1'b0;
    expect_at(b + 18, M_ST,    vec(3'b110, 3'b111, 3'b111), "errmrst_hold");
    expect_at(b + 19, M_ST_EN, vec(3'b001, 3'b111, 3'b111), "errmrst_exit");
    expect_at(b + 20, M_ALL,   vec(3'b111, 3'b111, 3'b111), "errusb_entry");
    expect_at(b + 21, M_ALL,   vec(3'b111, 3'b111, 3'b011), "fast_lit_first");
    expect_at(b + 24, M_ALL,   vec(3'b111, 3'b111, 3'b011), "fast_lit_last");
    expect_at(b + 25, M_ALL,   vec(3'b111, 3'b111, 3'b111), "fast_dark_first");
    expect_at(b + 28, M_ALL,   vec(3'b111, 3'b111, 3'b111), "fast_dark_last");
    expect_at(b + 29, M_ALL,   vec(3'b111, 3'b111, 3'b011), "fast_relit");
    wait_cycles(32);

    // Both high: ERR_USB -> SETTLE -> MPSSE, standby slow blink.
    b = cyc; MRST = 1'b1;
    expect_at(b + 18, M_ST_EN, vec(3'b111, 3'b111, 3'b111), "errusb_hold");
    expect_at(b + 19, M_ST_EN, vec(3'b001, 3'b111, 3'b111), "errusb_exit");
    expect_at(b + 20, M_ALL,   vec(3'b101, 3'b111, 3'b111), "mpsse_entry");
    expect_at(b + 21, M_ALL,   vec(3'b101, 3'b110, 3'b101), "stby_lit_first");
    expect_at(b + 28, M_ALL,   vec(3'b101, 3'b110, 3'b101), "stby_lit_last");
    expect_at(b + 29, M_ALL,   vec(3'b101, 3'b110, 3'b111), "stby_dark_first");
    expect_at(b + 36, M_ALL,   vec(3'b101, 3'b110, 3'b111), "stby_dark_last");
    expect_at(b + 37, M_ALL,   vec(3'b101, 3'b110, 3'b101), "stby_relit");
    wait_cycles(40);

    // nDELAYING low forces STANDBY lit across both blink phases.
    b = cyc; nDELAYING = 1'b0;
    for (int i = 1; i <= 12; i++)
      expect_at(b + i, M_ALL, vec(3'b101, 3'b110, 3'b101), "stby_forced");
    wait_cycles(12); nDELAYING = 1'b1;
    wait_cycles(2);

    // Back to motherboard power: MPSSE -> DRAIN -> SETTLE -> EMULATOR.
    b = cyc; PWRSTAT = 1'b0; MRST = 1'b0;
    expect_at(b + 18, M_ST_EN, vec(3'b101, 3'b110, 3'b111), "mpsse_hold");
    expect_at(b + 19, M_ST_EN, vec(3'b011, 3'b110, 3'b111), "mpsse_drain");
    expect_at(b + 20, M_ALL,   vec(3'b011, 3'b111, 3'b111), "mpsse_drain_off");
    expect_at(b + 23, M_ALL,   vec(3'b001, 3'b111, 3'b111), "mpsse_resettle");
    expect_at(b + 24, M_ALL,   vec(3'b010, 3'b111, 3'b111), "emu_reentry");
    expect_at(b + 25, M_ALL,   vec(3'b010, 3'b000, 3'b011), "emu_reentry_out");
    wait_cycles(30);
    b = cyc; nDELAYING = 1'b0;
    expect_at(b + 1, M_ALL, vec(3'b010, 3'b000, 3'b000), "emu_delaying");
    expect_at(b + 3, M_ALL, vec(3'b010, 3'b000, 3'b000), "emu_delaying_hold");
    wait_cycles(5);

    // Asynchronous reset mid-operation, then a full re-settle.
    nRST = 1'b0; nDELAYING = 1'b1;
    #1;
    check_now("async_reset", vec(3'b000, 3'b111, 3'b111));
    wait_cycles(2);
    check_now("reset_held", vec(3'b000, 3'b111, 3'b111));
    nRST = 1'b1; b = cyc;
    expect_at(b + 1,  M_ALL, vec(3'b001, 3'b111, 3'b111), "re_settle_first");
    expect_at(b + 10, M_ALL, vec(3'b001, 3'b111, 3'b111), "re_settle_mid");
    expect_at(b + 18, M_ALL, vec(3'b001, 3'b111, 3'b111), "re_settle_last");
    expect_at(b + 19, M_ALL, vec(3'b010, 3'b111, 3'b111), "re_emu_entry");
    expect_at(b + 20, M_ALL, vec(3'b010, 3'b000, 3'b011), "re_emu_out");
    wait_cycles(25);

    while (sb.size() > 0) begin
      exp_t it;
      it = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL unretired %s due=%0d", it.name, it.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
